fir_window_feeder: RTL and testbench

Initiator and collector for the 11-PE systolic array in FIR mode.
- Holds the 11 tap coefficients.
- Accepts input samples over an AXI-Stream-style slave port and builds the 11-sample sliding window.
- Drives func_sel=1 and the 352-bit data/tap buses into the array.
- Captures each array result after its fixed pipeline latency and returns it over an AXI-Stream-style master port with full backpressure.

---
 rtl/fir_window_feeder.sv | 192 +++++++++++++++++++
 tb/tb_fir_window_feeder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_window_feeder.sv
// fir_window_feeder: drives the 11-PE systolic array in FIR mode.
// Holds the taps, builds the sliding sample window from the input stream,
// and collects each array result into a small FIFO that feeds the result stream.
// Output backpressure is handled with credits: a sample is accepted only while
// results in flight plus results already in the FIFO leave room in the FIFO.
// Optional build macro FIR_TLAST_CHECK_EN adds o_tlast_err, a sticky flag for
// an ss_tlast marker that does not line up with the run length.

module fir_win_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    // One window slot: cleared at run start, loads its neighbour on each accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= '0;
        else if (clr)   q <= '0;
        else if (shift) q <= d;
    end
endmodule

module fir_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAP    = 11,
    parameter int ARRAY_LAT  = 2,
    parameter int OBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_ap_start,
    input  logic [31:0]                   i_data_length,
    output logic                          o_ap_idle,
    output logic                          o_ap_done,
`ifdef FIR_TLAST_CHECK_EN
    output logic                          o_tlast_err,
`endif
    input  logic                          i_tap_wr_en,
    input  logic [3:0]                    i_tap_wr_addr,
    input  logic [DATA_WIDTH-1:0]         i_tap_wr_data,
    input  logic                          ss_tvalid,
    input  logic [DATA_WIDTH-1:0]         ss_tdata,
    input  logic                          ss_tlast,
    output logic                          ss_tready,
    output logic                          o_func_sel,
    output logic [NUM_TAP*DATA_WIDTH-1:0] o_fir_data,
    output logic [NUM_TAP*DATA_WIDTH-1:0] o_fir_tap,
    input  logic [DATA_WIDTH-1:0]         i_fir_result,
    output logic                          sm_tvalid,
    output logic [DATA_WIDTH-1:0]         sm_tdata,
    output logic                          sm_tlast,
    input  logic                          sm_tready
);
    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;
    logic [31:0] length, in_cnt, out_cnt, inflight;
    logic [NUM_TAP-1:0][DATA_WIDTH-1:0] win, taps;
    // vld_pipe[0] marks a window registered this cycle; vld_pipe[ARRAY_LAT]
    // lines up with the matching result on i_fir_result.
    logic [ARRAY_LAT:0]    vld_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [OBUF_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         fifo_cnt;
    logic start, accept, push, pop, last_in, last_out;

    assign start    = (state == S_IDLE) && i_ap_start;
    assign accept   = ss_tvalid && ss_tready;
    assign push     = vld_pipe[ARRAY_LAT];
    assign pop      = sm_tvalid && sm_tready;
    assign last_in  = accept && (in_cnt + 32'd1 == length);
    assign last_out = pop && (out_cnt + 32'd1 == length);

    // Count results still travelling through the array
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ARRAY_LAT; i++) inflight = inflight + {31'd0, vld_pipe[i]};
    end

    // in_cnt != length only matters for a zero-length run: no sample is taken in its single RUN cycle
    assign ss_tready  = (state == S_RUN) && (in_cnt != length) &&
                        ((inflight + 32'(fifo_cnt)) < 32'(OBUF_DEPTH));
    assign o_ap_idle  = (state == S_IDLE);
    assign o_ap_done  = (state == S_DONE);
    assign o_func_sel = (state != S_IDLE);
    assign o_fir_data = win;
    assign o_fir_tap  = taps;
    assign sm_tvalid  = (fifo_cnt != '0);
    assign sm_tdata   = fifo_mem[rd_ptr];
    assign sm_tlast   = sm_tvalid && (out_cnt == length - 32'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: leave RUN on the last accepted sample, DRAIN on the last popped result
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_ap_start) state_nxt = S_RUN;
            S_RUN:   if (in_cnt == length || last_in) state_nxt = S_DRAIN;
            S_DRAIN: if (out_cnt == length || last_out) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run length and sample/result counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (start) begin
            length  <= i_data_length;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (accept) in_cnt  <= in_cnt + 32'd1;
            if (pop)    out_cnt <= out_cnt + 32'd1;
        end
    end

    // Tap registers, writable only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) taps <= '0;
        else if (state == S_IDLE && i_tap_wr_en && 32'(i_tap_wr_addr) < NUM_TAP)
            taps[i_tap_wr_addr] <= i_tap_wr_data;
    end

    // Sliding window: slot 0 takes the new sample, slot k takes slot k-1
    for (genvar k = 0; k < NUM_TAP; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_in;
        if (k == 0) begin : g_head
            assign slot_in = ss_tdata;
        end else begin : g_body
            assign slot_in = win[k-1];
        end
        fir_win_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk(clk), .rst(rst), .clr(start), .shift(accept), .d(slot_in), .q(win[k])
        );
    end

    // Valid shift pipe tracking windows presented to the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[ARRAY_LAT-1:0], accept};
    end

    // Result FIFO; credits on the input side guarantee a push never finds it full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OBUF_DEPTH; i++) fifo_mem[i] <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= i_fir_result;
                wr_ptr <= (wr_ptr == PW'(OBUF_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(OBUF_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef FIR_TLAST_CHECK_EN
    // Sticky flag for a tlast marker that disagrees with the run length
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        o_tlast_err <= 1'b0;
        else if (start) o_tlast_err <= 1'b0;
        else if (accept && (ss_tlast != (in_cnt == length - 32'd1))) o_tlast_err <= 1'b1;
    end
`else
    logic unused_tlast;
    assign unused_tlast = ss_tlast;
`endif

endmodule

// File: tb/tb_fir_window_feeder.sv
// Bench for fir_window_feeder: a two-stage array model drives i_fir_result,
// expected results come from a direct convolution of the sample list with the taps.
module tb_fir_window_feeder;
    localparam int DW = 32, NT = 11, LAT = 2, OBD = 4;

    logic clk, rst, i_ap_start, o_ap_idle, o_ap_done, i_tap_wr_en;
    logic [31:0] i_data_length;
    logic [3:0]  i_tap_wr_addr;
    logic [DW-1:0] i_tap_wr_data, ss_tdata, i_fir_result, sm_tdata;
    logic ss_tvalid, ss_tlast, ss_tready, o_func_sel, sm_tvalid, sm_tlast, sm_tready;
    logic [NT*DW-1:0] o_fir_data, o_fir_tap;
`ifdef FIR_TLAST_CHECK_EN
    logic o_tlast_err;
`endif

    fir_window_feeder #(.DATA_WIDTH(DW), .NUM_TAP(NT), .ARRAY_LAT(LAT), .OBUF_DEPTH(OBD)) dut (
        .clk(clk), .rst(rst), .i_ap_start(i_ap_start), .i_data_length(i_data_length),
        .o_ap_idle(o_ap_idle), .o_ap_done(o_ap_done),
`ifdef FIR_TLAST_CHECK_EN
        .o_tlast_err(o_tlast_err),
`endif
        .i_tap_wr_en(i_tap_wr_en), .i_tap_wr_addr(i_tap_wr_addr), .i_tap_wr_data(i_tap_wr_data),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .o_func_sel(o_func_sel), .o_fir_data(o_fir_data), .o_fir_tap(o_fir_tap),
        .i_fir_result(i_fir_result), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
        .sm_tlast(sm_tlast), .sm_tready(sm_tready)
    );

    typedef struct { logic [31:0] data; logic last; } exp_t;
    exp_t        exp_q[$];
    bit [31:0]   samp[$];
    bit [31:0]   tap_m[NT];
    int          n_checks = 0, n_fail = 0, done_cnt = 0, n_acc = 0;
    bit          bp_hold = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end

    // Array model: dot product of window and taps, ARRAY_LAT register stages
    function automatic logic [31:0] dot(input logic [NT*DW-1:0] d, input logic [NT*DW-1:0] t);
        logic [31:0] s = 0;
        for (int k = 0; k < NT; k++) s = s + d[32*k +: 32] * t[32*k +: 32];
        return s;
    endfunction
    logic [31:0] r1, r2;
    always @(posedge clk) begin
        r1 <= dot(o_fir_data, o_fir_tap);
        r2 <= r1;
    end
    assign i_fir_result = r2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output ready: random, or held low by the backpressure tests
    initial begin
        sm_tready = 0;
        forever begin
            @(posedge clk); #1;
            sm_tready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each handshaken result with the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_result: got %0h expected none", sm_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("sm_tdata", sm_tdata, e.data);
                    chk("sm_tlast", sm_tlast, e.last);
                end
            end
            if (o_ap_done) done_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: y[n] = sum_k tap[k] * x[n-k], samples before the run are zero
    task automatic push_exp(input int len);
        for (int n = 0; n < len; n++) begin
            bit [31:0] y = 0;
            for (int k = 0; k < NT; k++) if (n - k >= 0) y = y + tap_m[k] * samp[n-k];
            exp_q.push_back('{y, n == len - 1});
        end
    endtask

    function automatic logic [NT*DW-1:0] tap_vec();
        logic [NT*DW-1:0] v;
        for (int k = 0; k < NT; k++) v[32*k +: 32] = tap_m[k];
        return v;
    endfunction

    task automatic wr_tap(input int addr, input bit [31:0] data, input bit idle);
        i_tap_wr_en = 1; i_tap_wr_addr = 4'(addr); i_tap_wr_data = data;
        @(posedge clk); #1;
        i_tap_wr_en = 0;
        if (idle && addr < NT) tap_m[addr] = data;
    endtask

    task automatic set_taps(input int mode);  // 0 identity, 1 all ones, 2 random
        for (int k = 0; k < NT; k++)
            wr_tap(k, mode == 0 ? (k == 0 ? 1 : 0) : mode == 1 ? 1 : $urandom, 1);
    endtask

    task automatic start(input int len);
        i_data_length = len; i_ap_start = 1;
        @(posedge clk); #1;
        i_ap_start = 0;
        chk("func_sel_run", o_func_sel, 1);
        chk("idle_run", o_ap_idle, 0);
        chk("window_cleared", o_fir_data, '0);
    endtask

    task automatic feed(input int n, input int tlast_at);
        for (int i = 0; i < n; i++) begin
            bit got = 0;
            int cyc = 0;
            ss_tvalid = 1; ss_tdata = samp[i]; ss_tlast = (i == tlast_at);
            while (!got && cyc < 500) begin
                @(negedge clk); got = ss_tready;
                @(posedge clk); #1;
                cyc++;
            end
            if (got) n_acc++;
            else begin n_checks++; n_fail++; $display("FAIL feed_timeout: got no ready expected ready"); end
        end
        ss_tvalid = 0; ss_tlast = 0;
    endtask

    task automatic wait_done(input int d0);
        int cyc = 0;
        while (done_cnt == d0 && cyc < 3000) begin @(negedge clk); cyc++; end
        chk("done_pulse", done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("idle_after", o_ap_idle, 1);
        chk("func_sel_idle", o_func_sel, 0);
        @(posedge clk); #1;
    endtask

    task automatic do_run(input int len);
        int d0 = done_cnt;
        push_exp(len);
        start(len);
        feed(len, len - 1);
        wait_done(d0);
    endtask

    initial begin
        int d0;
        rst = 1; i_ap_start = 0; i_data_length = 0; i_tap_wr_en = 0; i_tap_wr_addr = 0;
        i_tap_wr_data = 0; ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
        repeat (3) @(negedge clk);
        chk("rst_idle", o_ap_idle, 1);
        chk("rst_done", o_ap_done, 0);
        chk("rst_ss_tready", ss_tready, 0);
        chk("rst_sm_tvalid", sm_tvalid, 0);
        chk("rst_sm_tdata", sm_tdata, 0);
        chk("rst_sm_tlast", sm_tlast, 0);
        chk("rst_func_sel", o_func_sel, 0);
        chk("rst_fir_data", o_fir_data, '0);
        chk("rst_fir_tap", o_fir_tap, '0);
        @(posedge clk); #1; rst = 0;

        // Identity taps, 5,6,7 -> 5,6,7
        set_taps(0);
        chk("tap_view", o_fir_tap, tap_vec());
        samp = {5, 6, 7};
        do_run(3);

        // Out-of-range tap address is ignored
        wr_tap(11, 32'hdead_beef, 1);
        chk("tap_addr_oob", o_fir_tap, tap_vec());

        // Ramp with all-ones taps
        set_taps(1);
        samp.delete();
        for (int i = 1; i <= 12; i++) samp.push_back(i);
        do_run(12);
        chk("window_slot0", o_fir_data[31:0], 12);
        chk("window_slot1", o_fir_data[63:32], 11);

        // Zero-length run
        samp.delete();
        do_run(0);

        // Backpressure: only OBUF_DEPTH samples get in while results cannot leave
        set_taps(0);
        samp.delete();
        for (int i = 0; i < 8; i++) samp.push_back(100 + i);
        @(negedge clk); bp_hold = 1;
        @(posedge clk); #1;
        d0 = done_cnt; n_acc = 0;
        push_exp(8);
        start(8);
        fork feed(8, 7); join_none
        repeat (20) @(negedge clk);
        chk("bp_accepted", n_acc, OBD);
        chk("bp_ss_tready", ss_tready, 0);
        chk("bp_sm_tvalid", sm_tvalid, 1);
        bp_hold = 0;
        wait fork;
        wait_done(d0);

        // Tap write during RUN is ignored
        samp.delete();
        for (int i = 0; i < 8; i++) samp.push_back(30 + i);
        d0 = done_cnt;
        push_exp(8);
        start(8);
        fork feed(8, 7); join_none
        @(posedge clk); #1;
        wr_tap(0, 9, 0);
        wait fork;
        wait_done(d0);
        chk("tap_write_in_run", o_fir_tap[31:0], 1);

        // Reset mid-run after 3 of 8 samples
        @(negedge clk); bp_hold = 1;
        @(posedge clk); #1;
        samp = {1, 2, 3};
        start(8);
        feed(3, -1);
        repeat (5) @(negedge clk);
        chk("pre_rst_sm_tvalid", sm_tvalid, 1);
        chk("pre_rst_ss_tready", ss_tready, 1);
        rst = 1; #1;
        chk("mid_rst_sm_tvalid", sm_tvalid, 0);
        chk("mid_rst_idle", o_ap_idle, 1);
        chk("mid_rst_ss_tready", ss_tready, 0);
        chk("mid_rst_taps", o_fir_tap, '0);
        for (int k = 0; k < NT; k++) tap_m[k] = 0;
        exp_q.delete();
        @(posedge clk); #1; rst = 0; bp_hold = 0;
        set_taps(0);
        samp = {4, 5};
        do_run(2);

        // Random taps, lengths and samples
        for (int it = 0; it < 4; it++) begin
            int len = $urandom_range(1, 20);
            set_taps(2);
            samp.delete();
            for (int i = 0; i < len; i++) samp.push_back($urandom);
            do_run(len);
        end

`ifdef FIR_TLAST_CHECK_EN
        // Early tlast marker is flagged and the flag holds until the next start
        set_taps(0);
        samp = {1, 2, 3, 4};
        d0 = done_cnt;
        push_exp(4);
        start(4);
        chk("tlast_err_clear", o_tlast_err, 0);
        feed(4, 1);
        chk("tlast_err_set", o_tlast_err, 1);
        wait_done(d0);
        chk("tlast_err_sticky", o_tlast_err, 1);
        d0 = done_cnt;
        start(0);
        chk("tlast_err_restart", o_tlast_err, 0);
        wait_done(d0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
